// File: rtl/otbn_bignum_mul256_seq.sv
// Drives the bignum MAC through the fixed 16-step MULQACC schedule and
// assembles the 512-bit product from the four half-words shifted out on .SO steps.
module otbn_bignum_mul256_seq #(
  parameter int WLEN = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [WLEN-1:0]   operand_a_i,
  input  logic [WLEN-1:0]   operand_b_i,
  input  logic              stall_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [2*WLEN-1:0] result_o,
  output logic              mac_en_o,
  output logic              mac_commit_o,
  output logic [WLEN-1:0]   mac_op_a_o,
  output logic [WLEN-1:0]   mac_op_b_o,
  output logic [1:0]        mac_a_qw_sel_o,
  output logic [1:0]        mac_b_qw_sel_o,
  output logic [1:0]        mac_shift_imm_o,
  output logic              mac_zero_acc_o,
  output logic              mac_shift_acc_o,
  output logic              mac_wr_hw_sel_upper_o,
  output logic              mac_predec_op_en_o,
  output logic              mac_predec_acc_rd_en_o,
  input  logic [WLEN-1:0]   mac_result_i,
  input  logic              mac_intg_err_i,
  input  logic              mac_predec_err_i
);
  localparam int HWLEN = WLEN / 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_e;

  state_e          state_reg;
  logic [3:0]      step_reg;
  logic [WLEN-1:0] op_a_reg;
  logic [WLEN-1:0] op_b_reg;
  logic            err_reg;

  logic [1:0] a_sel, b_sel, shift_imm, so_k;
  logic       zero_acc, so_step, hw_upper;
  logic       run, mac_err, accept, step_fire, capture;
  logic       unused_res_hi;

  assign unused_res_hi = ^mac_result_i[WLEN-1:HWLEN];

  // Quarter-word products grouped by weight; .SO retires 128 bits of product.
  always_comb begin
    a_sel     = 2'd0;
    b_sel     = 2'd0;
    shift_imm = 2'd0;
    zero_acc  = 1'b0;
    so_step   = 1'b0;
    hw_upper  = 1'b0;
    so_k      = 2'd0;
    case (step_reg)
      4'd0:  begin {a_sel, b_sel, shift_imm} = {2'd0, 2'd0, 2'd0}; zero_acc = 1'b1; end
      4'd1:  {a_sel, b_sel, shift_imm} = {2'd1, 2'd0, 2'd1};
      4'd2:  begin {a_sel, b_sel, shift_imm} = {2'd0, 2'd1, 2'd1}; so_step = 1'b1; so_k = 2'd0; end
      4'd3:  {a_sel, b_sel, shift_imm} = {2'd2, 2'd0, 2'd0};
      4'd4:  {a_sel, b_sel, shift_imm} = {2'd1, 2'd1, 2'd0};
      4'd5:  {a_sel, b_sel, shift_imm} = {2'd0, 2'd2, 2'd0};
      4'd6:  {a_sel, b_sel, shift_imm} = {2'd3, 2'd0, 2'd1};
      4'd7:  {a_sel, b_sel, shift_imm} = {2'd2, 2'd1, 2'd1};
      4'd8:  {a_sel, b_sel, shift_imm} = {2'd1, 2'd2, 2'd1};
      4'd9:  begin
        {a_sel, b_sel, shift_imm} = {2'd0, 2'd3, 2'd1};
        so_step = 1'b1; hw_upper = 1'b1; so_k = 2'd1;
      end
      4'd10: {a_sel, b_sel, shift_imm} = {2'd3, 2'd1, 2'd0};
      4'd11: {a_sel, b_sel, shift_imm} = {2'd2, 2'd2, 2'd0};
      4'd12: {a_sel, b_sel, shift_imm} = {2'd1, 2'd3, 2'd0};
      4'd13: {a_sel, b_sel, shift_imm} = {2'd3, 2'd2, 2'd1};
      4'd14: begin {a_sel, b_sel, shift_imm} = {2'd2, 2'd3, 2'd1}; so_step = 1'b1; so_k = 2'd2; end
      default: begin
        {a_sel, b_sel, shift_imm} = {2'd3, 2'd3, 2'd0};
        so_step = 1'b1; hw_upper = 1'b1; so_k = 2'd3;
      end
    endcase
  end

  assign run       = (state_reg == RUN);
  assign mac_err   = run & (mac_intg_err_i | mac_predec_err_i);
  assign accept    = start_i & ~abort_i & ((state_reg == IDLE) | (state_reg == ERR));
  assign step_fire = run & ~stall_i & ~mac_err & ~abort_i;
  assign capture   = step_fire & so_step;

  assign busy_o                 = run;
  assign done_o                 = (state_reg == DONE);
  assign err_o                  = err_reg;
  assign mac_en_o               = run;
  assign mac_commit_o           = run & ~stall_i;
  assign mac_op_a_o             = run ? op_a_reg : '0;
  assign mac_op_b_o             = run ? op_b_reg : '0;
  assign mac_a_qw_sel_o         = run ? a_sel : 2'd0;
  assign mac_b_qw_sel_o         = run ? b_sel : 2'd0;
  assign mac_shift_imm_o        = run ? shift_imm : 2'd0;
  assign mac_zero_acc_o         = run & zero_acc;
  assign mac_shift_acc_o        = run & so_step;
  assign mac_wr_hw_sel_upper_o  = run & hw_upper;
  assign mac_predec_op_en_o     = mac_en_o;
  assign mac_predec_acc_rd_en_o = mac_en_o & ~mac_zero_acc_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      step_reg  <= 4'd0;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      err_reg   <= 1'b0;
    end else if (abort_i) begin
      state_reg <= IDLE;
      step_reg  <= 4'd0;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      err_reg   <= 1'b0;
    end else if (accept) begin
      state_reg <= RUN;
      step_reg  <= 4'd0;
      op_a_reg  <= operand_a_i;
      op_b_reg  <= operand_b_i;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (mac_err) begin
            state_reg <= ERR;
            err_reg   <= 1'b1;
          end else if (!stall_i) begin
            step_reg <= step_reg + 4'd1;
            if (step_reg == 4'd15) state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= state_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hw
      logic [HWLEN-1:0] hw_reg;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          hw_reg <= '0;
        end else if (abort_i || accept) begin
          hw_reg <= '0;
        end else if (capture && (so_k == 2'(gi))) begin
          hw_reg <= mac_result_i[HWLEN-1:0];
        end
      end
      assign result_o[gi*HWLEN +: HWLEN] = hw_reg;
    end
  endgenerate

endmodule
